// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALUop values, funct codes and
// the mul/div engine state enum.
package exec_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [5:0] FN_SLL   = 6'd0;
    localparam logic [5:0] FN_SRL   = 6'd2;
    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MFLO  = 6'd18;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_DIVU  = 6'd27;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_SLT   = 6'd42;

    typedef enum logic [1:0] {IDLE, MUL, DIV} md_state_t;

    function automatic logic is_muldiv(input logic [5:0] fn);
        return (fn == FN_MULTU) || (fn == FN_DIVU);
    endfunction

    // Ops that depend on the engine and must wait while it is iterating.
    function automatic logic uses_hilo(input logic [5:0] fn);
        return is_muldiv(fn) || (fn == FN_MFHI) || (fn == FN_MFLO);
    endfunction

endpackage

// File: rtl/exec_unit_p_if.sv
// EX-stage request/response bundle between the pipeline and exec_unit_p.
interface exec_unit_p_if #(
    parameter int unsigned WIDTH = 32
);
    logic             valid_in;
    logic [1:0]       ALUop;
    logic [5:0]       Signal;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [WIDTH-1:0] Output;
    logic             zero;
    logic             ovf;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output valid_in, ALUop, Signal, dataA, dataB,
        input  Output, zero, ovf, busy, done, stall
    );

    modport slave (
        input  valid_in, ALUop, Signal, dataA, dataB,
        output Output, zero, ovf, busy, done, stall
    );
endinterface

// File: rtl/seq_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine,
// one bit per cycle, results landing in HI/LO with a one-cycle done pulse.
module seq_muldiv
    import exec_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_busy,
    output logic             o_done
);
    localparam int unsigned CW = $clog2(WIDTH);

    md_state_t          r_state, w_state_next;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_op;
    logic [2*WIDTH-1:0] r_acc, w_acc_next;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic               r_done;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_last;

    // MUL: acc = {partial product, remaining multiplier bits}.
    // DIV: acc = {partial remainder, remaining dividend bits / quotient bits}.
    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_sum        = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_op : '0)};
        w_shift      = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_diff       = w_shift - {1'b0, r_op};
        w_last       = (r_cnt == CW'(WIDTH - 1));
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_next = i_div ? DIV : MUL;
                    w_acc_next   = {{WIDTH{1'b0}}, (i_div ? i_a : i_b)};
                end
            end
            MUL: begin
                w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
                if (w_last) w_state_next = IDLE;
            end
            DIV: begin
                // A borrow means the divisor did not fit: restore and shift in 0.
                if (w_diff[WIDTH]) begin
                    w_acc_next = {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
                end else begin
                    w_acc_next = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
                end
                if (w_last) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_acc   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_done  <= 1'b0;
            if (r_state == IDLE) begin
                r_cnt <= '0;
                if (i_start) r_op <= i_div ? i_b : i_a;
            end else begin
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    r_hi   <= w_acc_next[2*WIDTH-1:WIDTH];
                    r_lo   <= w_acc_next[WIDTH-1:0];
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    assign o_busy = (r_state != IDLE);
    assign o_done = r_done;

endmodule

// File: rtl/exec_unit_p.sv
// Execute-stage unit: combinational ALU/shifter with flags, plus the
// sequential mul/div engine and the stall it imposes on dependent ops.
module exec_unit_p
    import exec_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input logic          clk,
    input logic          rst,
    exec_unit_p_if.slave bus
);
    logic [WIDTH-1:0] w_a, w_b;
    logic [WIDTH-1:0] w_sum, w_dif;
    logic [SHW-1:0]   w_shamt;
    logic             w_add_ovf, w_sub_ovf;
    logic [WIDTH-1:0] w_result;
    logic             w_ovf;
    logic             w_funct;
    logic             w_issue;
    logic [WIDTH-1:0] w_hi, w_lo;
    logic             w_busy, w_done;

    assign w_a     = bus.dataA;
    assign w_b     = bus.dataB;
    assign w_sum   = w_a + w_b;
    assign w_dif   = w_a - w_b;
    assign w_shamt = w_b[SHW-1:0];

    assign w_add_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
    assign w_sub_ovf = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_dif[WIDTH-1] != w_a[WIDTH-1]);

    always_comb begin
        w_result = '0;
        w_ovf    = 1'b0;
        unique case (bus.ALUop)
            ALUOP_ADD, ALUOP_RSVD: begin
                w_result = w_sum;
                w_ovf    = w_add_ovf;
            end
            ALUOP_SUB: begin
                w_result = w_dif;
                w_ovf    = w_sub_ovf;
            end
            ALUOP_FUNCT: begin
                case (bus.Signal)
                    FN_AND:  w_result = w_a & w_b;
                    FN_OR:   w_result = w_a | w_b;
                    FN_ADD: begin
                        w_result = w_sum;
                        w_ovf    = w_add_ovf;
                    end
                    FN_SUB: begin
                        w_result = w_dif;
                        w_ovf    = w_sub_ovf;
                    end
                    FN_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
                    FN_SLL:  w_result = w_a << w_shamt;
                    FN_SRL:  w_result = w_a >> w_shamt;
                    FN_MFHI: w_result = w_hi;
                    FN_MFLO: w_result = w_lo;
                    // MULTU/DIVU and undefined codes produce no direct result.
                    default: w_result = '0;
                endcase
            end
            default: w_result = '0;
        endcase
    end

    assign w_funct = bus.valid_in && (bus.ALUop == ALUOP_FUNCT);
    assign w_issue = w_funct && is_muldiv(bus.Signal) && !w_busy;

    seq_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_issue),
        .i_div   (bus.Signal == FN_DIVU),
        .i_a     (w_a),
        .i_b     (w_b),
        .o_hi    (w_hi),
        .o_lo    (w_lo),
        .o_busy  (w_busy),
        .o_done  (w_done)
    );

    assign bus.Output = w_result;
    assign bus.zero   = (w_result == '0);
    assign bus.ovf    = w_ovf;
    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.stall  = w_busy && w_funct && uses_hilo(bus.Signal);

endmodule

// File: tb/tb_exec_unit_p.sv
// Scoreboard bench for exec_unit_p: stimulus queues expected responses,
// negedge monitor compares combinational outputs and mul/div completions.
module tb_exec_unit_p;
    import exec_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    exec_unit_p_if #(.WIDTH(32)) bus ();

    exec_unit_p #(
        .WIDTH (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] out;
        logic        ovf;
        logic        stall;
        logic        busy;
        logic        done;
    } exp_t;

    typedef struct {
        string name;
        int    cycles;
    } md_t;

    exp_t alu_q[$];
    md_t  md_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
        bus.valid_in = v;
        bus.ALUop    = op;
        bus.Signal   = fn;
        bus.dataA    = a;
        bus.dataB    = b;
    endtask

    task automatic expect_out(input string name, input logic [31:0] out, input logic ovf,
                              input logic stall, input logic busy, input logic done);
        exp_t e;
        e.name  = name;
        e.out   = out;
        e.ovf   = ovf;
        e.stall = stall;
        e.busy  = busy;
        e.done  = done;
        alu_q.push_back(e);
    endtask

    task automatic expect_md(input string name);
        md_t m;
        m.name   = name;
        m.cycles = 32;
        md_q.push_back(m);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!bus.done && n < 60) begin
            step();
            n++;
        end
        checks++;
        if (!bus.done) begin
            errors++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, required done=1", name,
                     bus.done, n);
        end
    endtask

    // Monitor: drains queued expectations and audits each done pulse.
    int   busy_cnt  = 0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        md_t  m;
        while (alu_q.size() > 0) begin
            e = alu_q.pop_front();
            checks++;
            if (bus.Output !== e.out || bus.zero !== (e.out == 32'd0) || bus.ovf !== e.ovf ||
                bus.stall !== e.stall || bus.busy !== e.busy || bus.done !== e.done) begin
                errors++;
                $display("FAIL %s: got out=%h z=%b ovf=%b stall=%b busy=%b done=%b, want out=%h z=%b ovf=%b stall=%b busy=%b done=%b",
                         e.name, bus.Output, bus.zero, bus.ovf, bus.stall, bus.busy, bus.done,
                         e.out, (e.out == 32'd0), e.ovf, e.stall, e.busy, e.done);
            end
        end
        if (!rst) begin
            busy_cnt  = 0;
            prev_done = 1'b0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                checks++;
                if (prev_done) begin
                    errors++;
                    $display("FAIL done_width: done high %0d consecutive cycles, want 1", 2);
                end else if (md_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: done=1 with no operation outstanding");
                end else begin
                    m = md_q.pop_front();
                    if (busy_cnt != m.cycles) begin
                        errors++;
                        $display("FAIL %s_busy_cycles: got %0d, want %0d", m.name, busy_cnt,
                                 m.cycles);
                    end
                end
                busy_cnt = 0;
            end
            prev_done = bus.done;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        drive(1'b0, ALUOP_ADD, 6'd0, 32'd0, 32'd0);
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;

        drive(1'b1, ALUOP_FUNCT, FN_MFHI, 32'd0, 32'd0);
        expect_out("reset_mfhi", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, ALUOP_FUNCT, FN_MFLO, 32'd0, 32'd0);
        expect_out("reset_mflo", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single-cycle ALU and flag vectors
        step(); drive(1'b1, ALUOP_FUNCT, FN_ADD, 32'h7FFF_FFFF, 32'h1);
        expect_out("add_ovf", 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(); drive(1'b1, ALUOP_FUNCT, FN_SUB, 32'd5, 32'd5);
        expect_out("sub_zero", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); drive(1'b1, ALUOP_FUNCT, FN_SUB, 32'h8000_0000, 32'h1);
        expect_out("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        step(); drive(1'b1, ALUOP_FUNCT, FN_SLT, 32'hFFFF_FFFF, 32'h1);
        expect_out("slt_neg", 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); drive(1'b1, ALUOP_FUNCT, FN_SLT, 32'h1, 32'hFFFF_FFFF);
        expect_out("slt_pos", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); drive(1'b1, ALUOP_FUNCT, FN_SRL, 32'h8000_0000, 32'd31);
        expect_out("srl_31", 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); drive(1'b1, ALUOP_FUNCT, FN_SLL, 32'h1, 32'h24);
        expect_out("sll_amt_mask", 32'd16, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); drive(1'b1, ALUOP_FUNCT, FN_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
        expect_out("and", 32'hF000_F000, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); drive(1'b1, ALUOP_FUNCT, FN_OR, 32'hF0F0_F0F0, 32'hFF00_FF00);
        expect_out("or", 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); drive(1'b1, ALUOP_SUB, 6'd0, 32'd3, 32'd5);
        expect_out("aluop_sub", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); drive(1'b1, ALUOP_ADD, 6'd0, 32'd2, 32'd3);
        expect_out("aluop_add", 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); drive(1'b1, ALUOP_RSVD, 6'd0, 32'd2, 32'd3);
        expect_out("aluop_rsvd", 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); drive(1'b1, ALUOP_FUNCT, 6'd63, 32'd5, 32'd6);
        expect_out("undef_funct", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset aborts an in-flight MULTU
        step(); drive(1'b1, ALUOP_FUNCT, FN_MULTU, 32'd5, 32'd6);
        expect_out("abort_issue", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("abort_busy_stall", 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(); drive(1'b0, ALUOP_ADD, 6'd0, 32'd0, 32'd0);
        rst = 1'b0;
        step();
        expect_out("abort_in_reset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        drive(1'b1, ALUOP_FUNCT, FN_MFHI, 32'd0, 32'd0);
        expect_out("abort_mfhi", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); drive(1'b1, ALUOP_FUNCT, FN_MFLO, 32'd0, 32'd0);
        expect_out("abort_mflo", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // MULTU max x max
        step(); drive(1'b1, ALUOP_FUNCT, FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        expect_md("multu_max");
        expect_out("multu_issue", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); drive(1'b0, ALUOP_ADD, 6'd0, 32'd0, 32'd0);
        wait_done("multu_max");
        drive(1'b1, ALUOP_FUNCT, FN_MFHI, 32'd0, 32'd0);
        expect_out("multu_hi", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        step(); drive(1'b1, ALUOP_FUNCT, FN_MFLO, 32'd0, 32'd0);
        expect_out("multu_lo", 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);

        // DIVU 100 / 7
        step(); drive(1'b1, ALUOP_FUNCT, FN_DIVU, 32'd100, 32'd7);
        expect_md("divu_100_7");
        step(); drive(1'b0, ALUOP_ADD, 6'd0, 32'd0, 32'd0);
        wait_done("divu_100_7");
        drive(1'b1, ALUOP_FUNCT, FN_MFHI, 32'd0, 32'd0);
        expect_out("divu_hi", 32'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        step(); drive(1'b1, ALUOP_FUNCT, FN_MFLO, 32'd0, 32'd0);
        expect_out("divu_lo", 32'd14, 1'b0, 1'b0, 1'b0, 1'b0);

        // DIVU by zero
        step(); drive(1'b1, ALUOP_FUNCT, FN_DIVU, 32'h1234, 32'd0);
        expect_md("divu_by_0");
        step(); drive(1'b0, ALUOP_ADD, 6'd0, 32'd0, 32'd0);
        wait_done("divu_by_0");
        drive(1'b1, ALUOP_FUNCT, FN_MFHI, 32'd0, 32'd0);
        expect_out("div0_hi", 32'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
        step(); drive(1'b1, ALUOP_FUNCT, FN_MFLO, 32'd0, 32'd0);
        expect_out("div0_lo", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);

        // Hazard: ADD flows through, MFLO stalls until the done cycle
        step(); drive(1'b1, ALUOP_FUNCT, FN_MULTU, 32'd6, 32'd7);
        expect_md("multu_hazard");
        step(); drive(1'b0, ALUOP_ADD, 6'd0, 32'd0, 32'd0);
        step(); drive(1'b1, ALUOP_FUNCT, FN_ADD, 32'd1, 32'd1);
        expect_out("hazard_add", 32'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        step(); drive(1'b1, ALUOP_FUNCT, FN_MFLO, 32'd0, 32'd0);
        n = 0;
        while (!bus.done && n < 60) begin
            expect_out("hazard_stall", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0);
            step();
            n++;
        end
        checks++;
        if (!bus.done) begin
            errors++;
            $display("FAIL hazard_timeout: done=%b after %0d cycles, required done=1",
                     bus.done, n);
        end else begin
            expect_out("hazard_mflo", 32'd42, 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Back-to-back: DIVU waits behind MULTU, accepted in its done cycle
        step(); drive(1'b1, ALUOP_FUNCT, FN_MULTU, 32'd3, 32'd4);
        expect_md("b2b_multu");
        expect_out("b2b_issue1", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); drive(1'b1, ALUOP_FUNCT, FN_DIVU, 32'd12, 32'd5);
        expect_out("b2b_divu_stall", 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_done("b2b_multu");
        expect_out("b2b_divu_accept", 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_md("b2b_divu");
        step(); drive(1'b1, ALUOP_FUNCT, FN_MFHI, 32'd0, 32'd0);
        expect_out("b2b_mid_hi", 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(); drive(1'b1, ALUOP_FUNCT, FN_MFLO, 32'd0, 32'd0);
        expect_out("b2b_mid_lo", 32'd12, 1'b0, 1'b1, 1'b1, 1'b0);
        step(); drive(1'b0, ALUOP_ADD, 6'd0, 32'd0, 32'd0);
        wait_done("b2b_divu");
        drive(1'b1, ALUOP_FUNCT, FN_MFHI, 32'd0, 32'd0);
        expect_out("b2b_final_hi", 32'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        step(); drive(1'b1, ALUOP_FUNCT, FN_MFLO, 32'd0, 32'd0);
        expect_out("b2b_final_lo", 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);

        step(); drive(1'b0, ALUOP_ADD, 6'd0, 32'd0, 32'd0);
        step();
        step();
        checks++;
        if (md_q.size() != 0 || alu_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: md_q=%0d alu_q=%0d outstanding, want 0 and 0",
                     md_q.size(), alu_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
